vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Memory-side responder for the screen controller's fetch interface.
- Owns the shared video SRAM port and arbitrates 14 MHz slots between screen fetches and CPU accesses.
- Serves ULAplus palette reads (fetch_up) from an internal 64x8 palette; those reads never touch SRAM.
- Sits between the screen controller, the CPU bus interface and the external SRAM pins.

Parameters:
- BANK_NORMAL, 5, 16K SRAM bank holding the normal screen.
- BANK_SHADOW, 7, 16K SRAM bank holding the shadow screen.
- CPU_MAX_WAIT, 3, consecutive lost slots after which a pending CPU access wins the next slot.

Ports:
- clk28 input 1 28 MHz system clock
- rst input 1 reset, asynchronous, active-high
- ck14 input 1 slot strobe; a slot is 2 clk28 cycles and the boundary is a clk28 edge with ck14=1
- screen_page input 1 0=BANK_NORMAL, 1=BANK_SHADOW
- fetch input 1 screen fetch active for the current slot
- fetch_up input 1 current fetch is a palette fetch
- addr input 15 screen byte address; bits 13:0 used
- up_addr input 6 palette index
- fetch_allow output 1 screen may claim the next slot
- fetch_data output 8 fetched byte, valid at the slot-end edge
- cpu_req input 1 level; held until cpu_ack
- cpu_wr input 1 1=write
- cpu_addr input 19 SRAM byte address
- cpu_wdata input 8 write data
- cpu_rdata output 8 read data, valid while cpu_ack=1
- cpu_ack output 1 one clk28 pulse on completion
- pal_we input 1 palette write strobe, one clk28
- pal_waddr input 6 palette write index
- pal_wdata input 8 palette write data
- sram_addr output 19 SRAM address
- sram_dout output 8 SRAM write data
- sram_din input 8 SRAM read data
- sram_drive output 1 enable FPGA drive of the data bus
- sram_we_n output 1 active-low write enable
- sram_oe_n output 1 active-low output enable

Behaviour:
- Reset values:
  - fetch_allow=1, fetch_data=0, cpu_rdata=0, cpu_ack=0.
  - sram_addr=0, sram_dout=0, sram_drive=0, sram_we_n=1, sram_oe_n=1.
  - Palette cleared to 0, wait counter 0, state IDLE.
- Slot phases:
  - Phase 0 is the clk28 cycle after a ck14 edge.
  - Phase 1 is the cycle ending at the next ck14 edge.
  - The state is decided at each ck14 edge and holds for the whole slot.
- States: IDLE, VIDEO, PAL, CPU_RD, CPU_WR.
- Slot decision at a ck14 edge, first matching rule wins:
  - cpu_req and wait_cnt==CPU_MAX_WAIT -> CPU_RD or CPU_WR.
  - fetch and !fetch_up -> VIDEO.
  - fetch and fetch_up -> PAL; if cpu_req, the CPU is also served in the same slot (the palette needs no SRAM).
  - cpu_req -> CPU_RD or CPU_WR.
  - Otherwise -> IDLE.
- fetch_allow is registered at each ck14 edge as !(cpu_req && wait_cnt>=CPU_MAX_WAIT-1). Deasserting it one slot early guarantees the screen leaves the forced CPU slot free.
- If the screen still asserts fetch in a forced CPU slot, the CPU wins and fetch_data holds its previous value.
- wait_cnt:
  - Increments, saturating at CPU_MAX_WAIT, on each slot where cpu_req=1 and the CPU is not served.
  - Clears when the CPU is served or when cpu_req=0.
- VIDEO slot:
  - sram_addr = {bank(3b), addr[13:0]}, sram_oe_n=0.
  - fetch_data <= sram_din at the phase-0 edge, so it is valid at slot end; read latency is 1 slot.
- PAL slot: fetch_data <= palette[up_addr] at the phase-0 edge.
- CPU_RD slot:
  - sram_addr=cpu_addr, sram_oe_n=0.
  - cpu_rdata <= sram_din and cpu_ack=1 on the phase-1 cycle.
- CPU_WR slot:
  - sram_drive=1 for the whole slot; sram_we_n=0 in phase 0 only, giving setup/hold margin.
  - cpu_ack=1 on the phase-1 cycle.
- cpu_req sampled low at a decision edge is ignored. A request is never served twice: after cpu_ack, the next slot decision masks cpu_req for one slot.
- Palette write:
  - Takes effect on the next clk28 edge.
  - A PAL read of the same index in the same cycle returns the old value.
- Reset mid-slot: all outputs return to reset values immediately; an aborted CPU access produces no cpu_ack.

Decomposition:
- Shared package common: slot_state_t enum (IDLE, VIDEO, PAL, CPU_RD, CPU_WR) and the bank constants.
- Sub-module up_palette: 64x8 register file with a synchronous write port and a registered read port.

Test Plan:
- fetch=1, fetch_up=0, addr=0x1800, screen_page=1, SRAM model returns 0x5A -> sram_addr=0x1D800, fetch_data=0x5A at the slot-end edge, no cpu_ack.
- Continuous screen fetch plus cpu_req read at 0x4000 (CPU_MAX_WAIT=3) -> fetch_allow low in slot 3, CPU served in slot 4, cpu_ack one cycle, cpu_rdata = model data.
- pal_we index 0x21 data 0xE3, then PAL fetch of up_addr=0x21 with cpu_req write 0x77 to 0x00100 -> fetch_data=0xE3, sram_we_n low exactly one cycle, SRAM[0x100]=0x77.
- pal_we and PAL read of index 5 in the same cycle (old value 0x00, new 0xFF) -> fetch_data=0x00; the next read returns 0xFF.
- Assert rst during phase 0 of a CPU_WR slot -> sram_we_n=1 and sram_drive=0 immediately, no cpu_ack, fetch_allow=1 after release.
- Idle bus, cpu_req read held -> cpu_ack within 1 slot, exactly one pulse, wait_cnt=0 afterwards.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared slot-state type and default constants for the video RAM arbiter.
package vram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VIDEO,
        PAL,
        CPU_RD,
        CPU_WR
    } slot_state_t;

    localparam logic [2:0]  DEF_BANK_NORMAL  = 3'd5;
    localparam logic [2:0]  DEF_BANK_SHADOW  = 3'd7;
    localparam int unsigned DEF_CPU_MAX_WAIT = 3;

endpackage

// File: rtl/vram_arbiter_up_palette.sv
// ULAplus 64x8 palette: synchronous write port, registered read port.
// A read and a write of the same index on one edge return the old entry.
module vram_arbiter_up_palette (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic       re,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [64];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem_q[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem_q[raddr];
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Video SRAM slot arbiter: shares 14 MHz slots between screen fetches and CPU
// accesses, and serves palette fetches from an internal register file.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter logic [2:0]  BANK_NORMAL  = DEF_BANK_NORMAL,
    parameter logic [2:0]  BANK_SHADOW  = DEF_BANK_SHADOW,
    parameter int unsigned CPU_MAX_WAIT = DEF_CPU_MAX_WAIT
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        ck14,
    input  logic        screen_page,
    input  logic        fetch,
    input  logic        fetch_up,
    input  logic [14:0] addr,
    input  logic [5:0]  up_addr,
    output logic        fetch_allow,
    output logic [7:0]  fetch_data,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        pal_we,
    input  logic [5:0]  pal_waddr,
    input  logic [7:0]  pal_wdata,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dout,
    input  logic [7:0]  sram_din,
    output logic        sram_drive,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    localparam int unsigned   WW        = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(CPU_MAX_WAIT);
    localparam logic [WW-1:0] WAIT_WARN = WW'(CPU_MAX_WAIT - 1);

    slot_state_t   state_q, nxt_state;
    logic          cpu_srv_q, cpu_wr_q, ph1_q, ack_mask_q;
    logic [WW-1:0] wait_cnt_q;
    logic          req_eff, srv;
    logic [2:0]    bank;
    logic [7:0]    pal_rdata;
    logic          unused_addr;

    assign unused_addr = addr[14];
    assign bank        = screen_page ? BANK_SHADOW : BANK_NORMAL;

    // Slot decision; a request just acknowledged is masked for one decision.
    always_comb begin
        req_eff   = cpu_req && !ack_mask_q;
        nxt_state = IDLE;
        srv       = 1'b0;
        if (req_eff && wait_cnt_q == WAIT_MAX) begin
            nxt_state = cpu_wr ? CPU_WR : CPU_RD;
            srv       = 1'b1;
        end else if (fetch && !fetch_up) begin
            nxt_state = VIDEO;
        end else if (fetch) begin
            nxt_state = PAL;
            srv       = req_eff;
        end else if (req_eff) begin
            nxt_state = cpu_wr ? CPU_WR : CPU_RD;
            srv       = 1'b1;
        end
    end

    vram_arbiter_up_palette u_palette (
        .clk   (clk28),
        .rst   (rst),
        .we    (pal_we),
        .waddr (pal_waddr),
        .wdata (pal_wdata),
        .re    (ck14 && nxt_state == PAL),
        .raddr (up_addr),
        .rdata (pal_rdata)
    );

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cpu_srv_q   <= 1'b0;
            cpu_wr_q    <= 1'b0;
            ph1_q       <= 1'b1;
            ack_mask_q  <= 1'b0;
            wait_cnt_q  <= '0;
            fetch_allow <= 1'b1;
            fetch_data  <= '0;
            cpu_rdata   <= '0;
            cpu_ack     <= 1'b0;
            sram_addr   <= '0;
            sram_dout   <= '0;
            sram_drive  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else if (ck14) begin
            state_q    <= nxt_state;
            cpu_srv_q  <= srv;
            cpu_wr_q   <= cpu_wr;
            ph1_q      <= 1'b0;
            ack_mask_q <= 1'b0;
            cpu_ack    <= 1'b0;
            if (!req_eff || srv) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_q <= wait_cnt_q + WW'(1);
            end
            // Drop the grant one slot early so the forced CPU slot stays free.
            fetch_allow <= !(req_eff && wait_cnt_q >= WAIT_WARN);
            sram_drive  <= srv && cpu_wr;
            sram_we_n   <= !(srv && cpu_wr);
            sram_oe_n   <= !(nxt_state == VIDEO || (srv && !cpu_wr));
            if (srv) begin
                sram_addr <= cpu_addr;
                if (cpu_wr) begin
                    sram_dout <= cpu_wdata;
                end
            end else if (nxt_state == VIDEO) begin
                sram_addr <= {2'b00, bank, addr[13:0]};
            end
        end else begin
            ph1_q     <= 1'b1;
            cpu_ack   <= 1'b0;
            sram_we_n <= 1'b1;
            if (!ph1_q) begin
                if (state_q == VIDEO) begin
                    fetch_data <= sram_din;
                end else if (state_q == PAL) begin
                    fetch_data <= pal_rdata;
                end
                if (cpu_srv_q) begin
                    cpu_ack    <= 1'b1;
                    ack_mask_q <= 1'b1;
                    if (!cpu_wr_q) begin
                        cpu_rdata <= sram_din;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected fetch bytes and
// CPU completions; a monitor compares them when the DUT presents them.
module tb_vram_arbiter;

    logic        clk28 = 1'b0;
    logic        rst = 1'b0;
    logic        ck14 = 1'b0;
    logic        screen_page = 1'b0;
    logic        fetch = 1'b0;
    logic        fetch_up = 1'b0;
    logic [14:0] addr = '0;
    logic [5:0]  up_addr = '0;
    logic        fetch_allow;
    logic [7:0]  fetch_data;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        pal_we = 1'b0;
    logic [5:0]  pal_waddr = '0;
    logic [7:0]  pal_wdata = '0;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din;
    logic        sram_drive;
    logic        sram_we_n;
    logic        sram_oe_n;

    vram_arbiter dut (
        .clk28       (clk28),
        .rst         (rst),
        .ck14        (ck14),
        .screen_page (screen_page),
        .fetch       (fetch),
        .fetch_up    (fetch_up),
        .addr        (addr),
        .up_addr     (up_addr),
        .fetch_allow (fetch_allow),
        .fetch_data  (fetch_data),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .pal_we      (pal_we),
        .pal_waddr   (pal_waddr),
        .pal_wdata   (pal_wdata),
        .sram_addr   (sram_addr),
        .sram_dout   (sram_dout),
        .sram_din    (sram_din),
        .sram_drive  (sram_drive),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    initial forever #5 clk28 = ~clk28;
    // ck14 high during the cycle that ends on a slot boundary.
    initial forever begin
        @(negedge clk28);
        ck14 = ~ck14;
    end

    logic [7:0] sram [0:524287];
    assign sram_din = sram_oe_n ? 8'h00 : sram[sram_addr];
    always @(posedge clk28) begin
        if (!sram_we_n && sram_drive) sram[sram_addr] <= sram_dout;
    end

    typedef struct {
        int unsigned slot;
        logic [7:0]  data;
    } fexp_t;
    typedef struct {
        bit         rd;
        logic [7:0] data;
    } aexp_t;

    fexp_t       fq[$];
    aexp_t       aq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned slot_cnt = 0;
    int unsigned we_low = 0;
    int unsigned s0, got_slot, we_before;
    bit          prev_ack = 1'b0;
    bit [5:1]    exp_allow = 5'b10011;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Both return 2 time units after a posedge; the monitor samples at +1.
    task automatic to_phase1();
        do begin @(posedge clk28); #2; end while (ck14);
    endtask
    task automatic to_phase0();
        do begin @(posedge clk28); #2; end while (!ck14);
    endtask

    // Monitor: ck14 still high one unit after a posedge marks a slot start.
    initial forever begin
        fexp_t f;
        aexp_t a;
        @(posedge clk28);
        #1;
        if (ck14) slot_cnt++;
        if (rst) begin
            prev_ack = 1'b0;
            continue;
        end
        if (!sram_we_n) we_low++;
        if (!ck14) begin
            while (fq.size() > 0 && fq[0].slot <= slot_cnt) begin
                f = fq.pop_front();
                chk("fetch_slot", 32'(slot_cnt), 32'(f.slot));
                chk("fetch_data", 32'(fetch_data), 32'(f.data));
            end
        end
        if (cpu_ack) begin
            chk("ack_pulse_width", 32'(prev_ack), 32'd0);
            chk("ack_in_phase1", 32'(ck14), 32'd0);
            chk("ack_expected", 32'(aq.size() > 0), 32'd1);
            if (aq.size() > 0) begin
                a = aq.pop_front();
                if (a.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(a.data));
            end
        end
        prev_ack = cpu_ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d of %0d vectors miscompared", n_err, n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        sram[19'h1D800] = 8'h5A;
        sram[19'h14123] = 8'h3C;
        sram[19'h14010] = 8'h11;
        sram[19'h04000] = 8'hC3;
        sram[19'h02345] = 8'h9B;
        sram[19'h00100] = 8'h00;
        sram[19'h00200] = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk28);
        #3 rst = 1'b0;
        #1;
        chk("rst_fetch_allow", 32'(fetch_allow), 32'd1);
        chk("rst_fetch_data", 32'(fetch_data), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_dout", 32'(sram_dout), 32'd0);
        chk("rst_sram_drive", 32'(sram_drive), 32'd0);
        chk("rst_sram_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_sram_oe_n", 32'(sram_oe_n), 32'd1);

        // Screen fetches from the shadow then the normal bank.
        to_phase1();
        s0 = slot_cnt;
        fetch = 1'b1; fetch_up = 1'b0; addr = 15'h1800; screen_page = 1'b1;
        fq.push_back('{s0 + 1, 8'h5A});
        to_phase0();
        chk("video_sram_addr_shadow", 32'(sram_addr), 32'h1D800);
        chk("video_oe_n", 32'(sram_oe_n), 32'd0);
        to_phase1();
        addr = 15'h0123; screen_page = 1'b0;
        fq.push_back('{s0 + 2, 8'h3C});
        to_phase0();
        chk("video_sram_addr_normal", 32'(sram_addr), 32'h14123);
        to_phase1();
        fetch = 1'b0;

        // Continuous fetch starves the CPU until the forced slot.
        to_phase1();
        s0 = slot_cnt;
        fetch = 1'b1; addr = 15'h0010; screen_page = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h04000;
        aq.push_back('{1'b1, 8'hC3});
        for (int k = 1; k <= 5; k++) fq.push_back('{s0 + k, 8'h11});
        got_slot = 0;
        for (int k = 1; k <= 5; k++) begin
            to_phase0();
            chk($sformatf("fetch_allow_slot%0d", k), 32'(fetch_allow), 32'(exp_allow[k]));
            if (k == 4) chk("forced_cpu_sram_addr", 32'(sram_addr), 32'h04000);
            to_phase1();
            if (cpu_ack && cpu_req) begin
                got_slot = slot_cnt;
                cpu_req = 1'b0;
            end
        end
        fetch = 1'b0;
        chk("forced_cpu_slot", 32'(got_slot), 32'(s0 + 4));

        // Palette write, then palette fetch sharing its slot with a CPU write.
        to_phase0();
        pal_we = 1'b1; pal_waddr = 6'h21; pal_wdata = 8'hE3;
        @(posedge clk28); #2;
        pal_we = 1'b0;
        to_phase1();
        s0 = slot_cnt;
        we_before = we_low;
        fetch = 1'b1; fetch_up = 1'b1; up_addr = 6'h21;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00100; cpu_wdata = 8'h77;
        fq.push_back('{s0 + 1, 8'hE3});
        aq.push_back('{1'b0, 8'h00});
        to_phase0();
        chk("pal_wr_we_n_ph0", 32'(sram_we_n), 32'd0);
        chk("pal_wr_drive_ph0", 32'(sram_drive), 32'd1);
        chk("pal_wr_sram_addr", 32'(sram_addr), 32'h00100);
        chk("pal_wr_sram_dout", 32'(sram_dout), 32'h77);
        to_phase1();
        chk("pal_wr_we_n_ph1", 32'(sram_we_n), 32'd1);
        chk("pal_wr_drive_ph1", 32'(sram_drive), 32'd1);
        chk("pal_wr_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0; cpu_wr = 1'b0; fetch = 1'b0; fetch_up = 1'b0;
        to_phase0();
        chk("pal_wr_drive_after", 32'(sram_drive), 32'd0);
        chk("we_low_cycles", 32'(we_low - we_before), 32'd1);
        chk("sram_written", 32'(sram[19'h00100]), 32'h77);

        // Palette write and read of one index on the same edge: old value first.
        to_phase1();
        s0 = slot_cnt;
        pal_we = 1'b1; pal_waddr = 6'd5; pal_wdata = 8'hFF;
        fetch = 1'b1; fetch_up = 1'b1; up_addr = 6'd5;
        fq.push_back('{s0 + 1, 8'h00});
        fq.push_back('{s0 + 2, 8'hFF});
        to_phase0();
        pal_we = 1'b0;
        to_phase1();
        to_phase1();
        fetch = 1'b0; fetch_up = 1'b0;

        // Idle bus: a CPU read is served in the very next slot.
        to_phase1();
        s0 = slot_cnt;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h02345;
        aq.push_back('{1'b1, 8'h9B});
        got_slot = 0;
        for (int k = 1; k <= 2; k++) begin
            to_phase1();
            if (cpu_ack && cpu_req) begin
                got_slot = slot_cnt;
                cpu_req = 1'b0;
            end
        end
        chk("idle_cpu_slot", 32'(got_slot), 32'(s0 + 1));
        to_phase1();
        to_phase1();

        // Reset in phase 0 of a CPU write aborts it without an acknowledge.
        to_phase1();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00200; cpu_wdata = 8'h55;
        to_phase0();
        chk("abort_we_n_before", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_drive", 32'(sram_drive), 32'd0);
        chk("abort_sram_addr", 32'(sram_addr), 32'd0);
        chk("abort_fetch_data", 32'(fetch_data), 32'd0);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        repeat (2) @(posedge clk28);
        #3 rst = 1'b0;
        to_phase0();
        chk("abort_fetch_allow", 32'(fetch_allow), 32'd1);
        to_phase1();
        to_phase1();
        chk("abort_sram_untouched", 32'(sram[19'h00200]), 32'h00);

        chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
        chk("ack_queue_drained", 32'(aq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
